// File: rtl/fp_add_pkg.sv
// ============================================================================
// Module      : fp_add_pkg
// Description : Shared types, constants and packing helper for the
//               floating-point add-and-normalize stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_add_pkg;

    localparam int MANT_W  = 24;
    localparam int EXP_W   = 8;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] ZERO_F32 = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    // Pack sign, biased exponent and normalized mantissa into IEEE single.
    // The hidden bit (mant[23]) is implicit in the encoding and dropped.
    function automatic logic [31:0] pack_f32(input logic        sign,
                                             input logic [7:0]  exp,
                                             input logic [23:0] mant);
        return {sign, exp, mant[22:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_mant_resolve.sv
// ============================================================================
// Module      : fp_mant_resolve
// Description : Combinational mantissa sum with sign resolution. Same-sign
//               sums report a carry and return the carry-adjusted mantissa;
//               opposite-sign sums return the magnitude and resolved sign.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mant_resolve #(
    parameter int MANT_W = 24
) (
    input  logic [MANT_W-1:0] za,
    input  logic [MANT_W-1:0] zb,
    input  logic              as,
    input  logic              bs,
    output logic              res_sign,
    output logic              carry,
    output logic [MANT_W-1:0] mag
);

    logic [MANT_W:0] sum;
    logic [MANT_W:0] neg;

    // Add the mantissas and derive sign/magnitude of the result.
    always_comb begin
        sum      = '0;
        neg      = '0;
        res_sign = as;
        carry    = 1'b0;
        mag      = '0;
        if (as == bs) begin
            sum   = {1'b0, za} + {1'b0, zb};
            carry = sum[MANT_W];
            // On carry the shifted-out LSB is truncated.
            mag   = carry ? sum[MANT_W:1] : sum[MANT_W-1:0];
        end else begin
            // zb arrives complemented; extend with a sign bit only when the
            // complement is non-zero (complement of zero is zero).
            sum = {1'b0, za} + {(|zb), zb};
            if (sum[MANT_W]) begin
                res_sign = bs;
                neg      = -sum;
                mag      = neg[MANT_W-1:0];
            end else begin
                res_sign = as;
                mag      = sum[MANT_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_add_norm_seq.sv
// ============================================================================
// Module      : fp_add_norm_seq
// Description : Sequential mantissa add and one-bit-per-cycle normalizer
//               producing an IEEE single result over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_add_norm_seq
    import fp_add_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] za,
    input  logic [MANT_W-1:0] zb,
    input  logic              as,
    input  logic              bs,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       z
);

    localparam logic [EXP_W-1:0] EXP_ALL1 = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] EXP_PRE1 = EXP_W'(EXP_MAX - 1);
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

    state_t            state_q, state_d;
    logic [MANT_W-1:0] za_q, za_d;
    logic [MANT_W-1:0] zb_q, zb_d;
    logic              as_q, as_d;
    logic              bs_q, bs_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              sign_q, sign_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       z_q, z_d;

    logic              res_sign;
    logic              carry;
    logic [MANT_W-1:0] mag;
    logic [EXP_W-1:0]  exp_sum;
    logic [MANT_W-1:0] mant_shl;
    logic              accept;

    fp_mant_resolve #(
        .MANT_W (MANT_W)
    ) u_resolve (
        .za       (za_q),
        .zb       (zb_q),
        .as       (as_q),
        .bs       (bs_q),
        .res_sign (res_sign),
        .carry    (carry),
        .mag      (mag)
    );

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign z         = z_q;

    assign exp_sum  = exp_q + EXP_W'(carry);
    assign mant_shl = {mant_q[MANT_W-2:0], 1'b0};

    // Next-state, datapath update and registered-output computation.
    always_comb begin
        state_d     = state_q;
        za_d        = za_q;
        zb_d        = zb_q;
        as_d        = as_q;
        bs_d        = bs_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        out_valid_d = 1'b0;
        z_d         = z_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    za_d    = za;
                    zb_d    = zb;
                    as_d    = as;
                    bs_d    = bs;
                    exp_d   = exp_in;
                    state_d = ADD;
                end
            end
            ADD: begin
                state_d = DONE;
                if ((mag == '0) || (exp_q == '0)) begin
                    sign_d = 1'b0;
                    exp_d  = '0;
                    mant_d = '0;
                end else if (exp_q == EXP_ALL1) begin
                    sign_d = as_q;
                    exp_d  = EXP_ALL1;
                    mant_d = '0;
                end else if (carry && (exp_q == EXP_PRE1)) begin
                    sign_d = res_sign;
                    exp_d  = EXP_ALL1;
                    mant_d = '0;
                end else begin
                    sign_d = res_sign;
                    exp_d  = exp_sum;
                    mant_d = mag;
                    if (!mag[MANT_W-1]) begin
                        if (exp_sum == EXP_ONE) begin
                            // Would need a denormal: flush to +0.
                            sign_d = 1'b0;
                            exp_d  = '0;
                            mant_d = '0;
                        end else begin
                            state_d = NORM;
                        end
                    end
                end
            end
            NORM: begin
                if (exp_q == EXP_ONE) begin
                    sign_d  = 1'b0;
                    exp_d   = '0;
                    mant_d  = '0;
                    state_d = DONE;
                end else begin
                    mant_d = mant_shl;
                    exp_d  = exp_q - EXP_ONE;
                    if (mant_shl[MANT_W-1]) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // First DONE cycle latches the packed result; valid follows.
                out_valid_d = !(out_valid_q && out_ready);
                if (!out_valid_q) begin
                    z_d = pack_f32(sign_q, exp_q, mant_q);
                end
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            za_q        <= '0;
            zb_q        <= '0;
            as_q        <= 1'b0;
            bs_q        <= 1'b0;
            mant_q      <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            z_q         <= ZERO_F32;
        end else begin
            state_q     <= state_d;
            za_q        <= za_d;
            zb_q        <= zb_d;
            as_q        <= as_d;
            bs_q        <= bs_d;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_add_norm_seq.sv
// ============================================================================
// Module      : tb_fp_add_norm_seq
// Description : Directed self-checking bench for fp_add_norm_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_add_norm_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] za;
    logic [23:0] zb;
    logic        as;
    logic        bs;
    logic [7:0]  exp_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;

    int compared;
    int failed;

    fp_add_norm_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .za        (za),
        .zb        (zb),
        .as        (as),
        .bs        (bs),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One transaction: drive, measure latency from the accept edge, check
    // the result, optionally stall the consumer, then confirm the handoff.
    task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                          input logic sa, input logic sb, input logic [7:0] e,
                          input logic [31:0] exp_z, input int exp_lat, input int hold);
        int lat;
        lat = -1;
        @(negedge clk);
        out_ready = (hold == 0);
        check({tag, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        za = a; zb = b; as = sa; bs = sb; exp_in = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        za = 24'hFFFFFF; zb = 24'hFFFFFF; exp_in = 8'h00;
        check({tag, " in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = c;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " z"}, z, exp_z);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, " hold_z"}, z, exp_z);
            check({tag, " hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, " hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, " in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        compared  = 0;
        failed    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        za = '0; zb = '0; as = 1'b0; bs = 1'b0; exp_in = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset z", z, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 + 1.0 (x2^0) -> carry, exponent bump
        run_op("add_2p0", 24'h800000, 24'h800000, 1'b0, 1'b0, 8'h7F, 32'h4000_0000, 2, 0);
        // 1.5 - 1.0 at 2^1 -> 0.5*2 = 1.0, one shift
        run_op("sub_pos", 24'hC00000, 24'h800000, 1'b0, 1'b1, 8'h80, 32'h3F80_0000, 3, 0);
        // 1.0 - 1.5 at 2^1 -> -1.0, one shift
        run_op("sub_neg", 24'h800000, 24'h400000, 1'b0, 1'b1, 8'h80, 32'hBF80_0000, 3, 0);
        // exact cancellation -> +0
        run_op("cancel", 24'hC00000, 24'h400000, 1'b0, 1'b1, 8'h85, 32'h0000_0000, 2, 0);
        // carry at exponent 254 -> -inf
        run_op("ovf_ninf", 24'h800000, 24'h800000, 1'b1, 1'b1, 8'hFE, 32'hFF80_0000, 2, 0);
        // input exponent 255 -> inf with sign of A
        run_op("exp_max", 24'h800000, 24'h000000, 1'b0, 1'b0, 8'hFF, 32'h7F80_0000, 2, 0);
        // input exponent 0 -> +0
        run_op("exp_zero", 24'h800000, 24'h000000, 1'b1, 1'b1, 8'h00, 32'h0000_0000, 2, 0);
        // magnitude 1 at exponent 1 -> flush to +0
        run_op("flush", 24'h800000, 24'h800001, 1'b0, 1'b1, 8'h01, 32'h0000_0000, 2, 0);
        // magnitude 1 at 0x90 -> 23 shifts, exponent 0x90-23 = 0x79
        run_op("norm23", 24'h800000, 24'h800001, 1'b0, 1'b1, 8'h90, 32'h3C80_0000, 25, 0);
        // consumer stall for 5 cycles
        run_op("stall", 24'hC00000, 24'h800000, 1'b0, 1'b1, 8'h80, 32'h3F80_0000, 3, 5);

        // Abort a long normalization with reset.
        @(negedge clk);
        za = 24'h800000; zb = 24'h800001; as = 1'b0; bs = 1'b1; exp_in = 8'h90;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_abort z_prev", z, 32'h3F80_0000);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort z", z, 32'h0);
        check("abort in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort no_result", 32'(seen), 32'd0);
        check("abort idle", {31'd0, in_ready}, 32'd1);

        // Block still operates after the abort.
        run_op("post_abort", 24'h800000, 24'h400000, 1'b0, 1'b1, 8'h80, 32'hBF80_0000, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

`default_nettype wire
